// File: rtl/mealy_bit_serializer_pkg.sv
// Shared types and frame-length helpers for the Mealy bit serializer.
// MEALY_SER_PARITY_EN adds one even-parity bit to every frame.
package mealy_bit_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEF_DATA_W = 8;

    function automatic int frame_len(input int data_w);
`ifdef MEALY_SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    localparam int FRAME_LEN = frame_len(DEF_DATA_W);
    localparam int BIT_CNT_W = $clog2(FRAME_LEN + 1);

endpackage

// File: rtl/mealy_bit_period_timer.sv
// Reloadable bit-period down-counter; o_tick marks the last cycle of a period.
// The reload value is captured on i_load and reused for every later period.
module mealy_bit_period_timer
    import mealy_bit_serializer_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_reload,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_reload;
    logic [DIV_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reload <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_reload <= i_reload;
            r_count  <= i_reload;
        end else if (i_en) begin
            if (r_count == '0)
                r_count <= r_reload;
            else
                r_count <= r_count - 1'b1;
        end
    end

    assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/mealy_bit_serializer.sv
// Parallel-to-serial feeder (LSB first) with a one-word holding buffer.
// Build option: MEALY_SER_PARITY_EN appends an even-parity bit per frame.
module mealy_bit_serializer
    import mealy_bit_serializer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIV_W-1:0]  div,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int FRAME_N = frame_len(DATA_W);
    localparam int CNT_W   = $clog2(FRAME_N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_N - 1);

    ser_state_e        r_state;
    ser_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_pend_full;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_bit_valid;
    logic              r_frame_start;

    logic              w_xfer;
    logic              w_tick;
    logic              w_load;
    logic              w_from_pend;
    logic              w_advance;
    logic              w_to_pend;
    logic [DATA_W-1:0] w_load_word;
    logic              w_cur_bit;

    assign w_xfer      = in_valid & ~r_pend_full;
    assign w_load_word = w_from_pend ? r_pend_data : in_data;
    assign w_to_pend   = w_xfer & ~w_load;

    mealy_bit_period_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_en     (r_state == SHIFT),
        .i_reload (div),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_from_pend = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        // Chain the next frame without a gap when a word is waiting.
                        if (r_pend_full) begin
                            w_load      = 1'b1;
                            w_from_pend = 1'b1;
                        end else if (w_xfer) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pend_data   <= '0;
            r_pend_full   <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_bit_valid   <= w_load | w_advance;
            r_frame_start <= w_load;
            if (w_load) begin
                r_shift   <= w_load_word;
                r_bit_cnt <= '0;
            end else if (w_advance) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_state_nxt == IDLE) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
            if (w_to_pend) begin
                r_pend_data <= in_data;
                r_pend_full <= 1'b1;
            end else if (w_from_pend) begin
                r_pend_full <= 1'b0;
            end
        end
    end

`ifdef MEALY_SER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_parity <= 1'b0;
        else if (w_load)
            r_parity <= ^w_load_word;
    end

    assign w_cur_bit = (r_bit_cnt == CNT_W'(DATA_W)) ? r_parity : r_shift[0];
`else
    assign w_cur_bit = r_shift[0];
`endif

    assign in_ready    = ~r_pend_full;
    assign busy        = (r_state == SHIFT);
    assign bit_out     = busy & w_cur_bit;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Scoreboard bench for mealy_bit_serializer: each accepted word queues its
// expected bits; a negedge monitor pops and checks every bit period.
module tb_mealy_bit_serializer;

    typedef struct {
        logic b;
        logic first;
        int   period;
    } exp_bit_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] div = '0;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_start;
    logic       busy;

    exp_bit_t exp_q[$];
    exp_bit_t e;
    logic     cur = 1'b0;
    int       hold = 0;
    logic     mon_en = 1'b0;
    int       n_checks = 0;
    int       n_errors = 0;
    int       waits;

    mealy_bit_serializer #(.DATA_W(8), .DIV_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .div         (div),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    check("bit_valid_without_expected_bit", bit_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_early", hold, 0);
                    check("bit_start", {busy, frame_start, bit_out}, {1'b1, e.first, e.b});
                    cur  = e.b;
                    hold = e.period - 1;
                end
            end else if (hold > 0) begin
                check("bit_hold", {busy, frame_start, bit_out}, {1'b1, 1'b0, cur});
                hold--;
            end else if (exp_q.size() != 0) begin
                check("missing_bit", bit_valid, 1'b1);
            end else begin
                check("idle", {busy, frame_start, bit_out}, 3'b000);
            end
        end
    end

    // Offers a word, waits (bounded) for acceptance, then queues its frame.
    task automatic send(input logic [7:0] w, input int period, output int n_wait);
        n_wait   = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n_wait < 200) begin
            @(posedge clk); #1;
            n_wait++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{b: w[i], first: (i == 0), period: period});
`ifdef MEALY_SER_PARITY_EN
        exp_q.push_back('{b: ^w, first: 1'b0, period: period});
`endif
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || hold != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000)
            check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_state", {in_ready, busy, bit_out, bit_valid, frame_start}, 5'b10000);
        mon_en = 1'b1;

        // div=0 single frame, then div=2 frame with long hold
        div = 4'd0;
        send(8'hA5, 1, waits);
        wait_drain();
        div = 4'd2;
        send(8'h01, 3, waits);
        wait_drain();

        // back-to-back: the third word waits for the buffer to drain
        div = 4'd0;
        send(8'h0F, 1, waits);
        send(8'hF0, 1, waits);
        check("b2b_second_no_wait", waits, 0);
        send(8'h33, 1, waits);
        check("b2b_third_wait_cycles", waits, 7);
        wait_drain();

        // reset mid-frame with a word pending: both are discarded
        send(8'hFF, 1, waits);
        send(8'h3C, 1, waits);
        check("pending_full_before_reset", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        hold = 0;
        check("after_reset", {in_ready, busy, bit_out, bit_valid, frame_start}, 5'b10000);
        repeat (12) @(posedge clk);
        #1;
        send(8'h80, 1, waits);
        wait_drain();

        // div raised mid-frame: current frame unaffected, next uses div=3
        div = 4'd0;
        send(8'h0F, 1, waits);
        repeat (2) @(posedge clk);
        #1;
        div = 4'd3;
        send(8'h5A, 4, waits);
        wait_drain();

        // parity-bearing frame when the option is built in
        div = 4'd0;
        send(8'h07, 1, waits);
        wait_drain();

        check("final_ready", in_ready, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mealy_bit_serializer.md
Name: mealy_bit_serializer

Overview:
- Upstream feeder for the serial Mealy FSM stage.
- Accepts parallel words over a valid/ready handshake and shifts them out LSB-first as a level-held serial bit stream.
- The bit stream drives the FSM's x1 input, at a programmable bit period.
- A one-entry holding buffer lets back-to-back words stream with no idle gap between frames.

Parameters:
- DATA_W, 8, width of each parallel word and number of data bits per frame.
- DIV_W, 4, width of the bit-period divider input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_data  input  DATA_W  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- div  input  DIV_W  bit period minus one, in clk cycles.
- bit_out  output  1  serial bit, held for the whole bit period; feeds the FSM x1 input.
- bit_valid  output  1  one-cycle strobe on the first cycle of each bit period.
- frame_start  output  1  one-cycle strobe coincident with bit_valid of bit 0.
- busy  output  1  a frame is being shifted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, shift register=0, pending buffer empty, bit counter=0, period counter=0.
  - Outputs: bit_out=0, bit_valid=0, frame_start=0, busy=0, in_ready=1.
  - Reset mid-frame aborts the frame and discards the pending word.
- Handshake:
  - Transfer occurs when in_valid & in_ready are both 1 at a clk edge.
  - in_ready = ~pending_full, driven from a register only; it never depends combinationally on in_valid.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On transfer, the word bypasses the buffer into the shift register; state=SHIFT on the next cycle.
  - div is latched into the period reload at frame load; changes to div mid-frame are ignored.
- Latency: a word accepted at edge T (IDLE, buffer empty) presents bit 0 in cycle T+1.
  - In cycle T+1: bit_valid=1, frame_start=1, busy=1.
- SHIFT:
  - Each bit is held for div+1 cycles. bit_valid pulses only on the first cycle of each bit.
  - Bit k begins at cycle T+1+k*(div+1).
  - Transfers during SHIFT write the pending buffer and set pending_full.
- End of the last bit period:
  - If pending_full: load the pending word into the shift register on that same edge, clear pending_full and start a new frame with no gap. The next cycle shows frame_start=1.
  - Otherwise: return to IDLE with bit_out=0 and busy=0.
- Simultaneous event:
  - When the pending buffer drains while in_valid=1, in_ready is still 0 in that cycle (no pass-through).
  - in_ready rises the cycle after the drain.
- Frame length: DATA_W bits (DATA_W+1 with the parity option).
  - Bit counter wraps to 0 at the end of each frame.
  - div=0 means one bit per cycle.

Optional Feature:
- MEALY_SER_PARITY_EN:
  - Defined: one extra bit period after the data bits carries even parity, ^word.
  - The frame is DATA_W+1 bits. bit_valid pulses for the parity bit too; the next frame starts after it.
- Undefined: frames are exactly DATA_W bits and no parity logic is present.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHIFT);
  - localparam FRAME_LEN = DATA_W or DATA_W+1, depending on the macro;
  - the bit-counter width, $clog2(FRAME_LEN+1).
- One sub-module: mealy_bit_period_timer.
  - Reloadable down-counter of width DIV_W.
  - Inputs: load and reload value.
  - Output: a tick on the last cycle of each bit period.

Test Plan:
- div=0, send 0xA5 at edge T:
  - bit_out=1,0,1,0,0,1,0,1 on cycles T+1..T+8.
  - frame_start only at T+1; busy for 8 cycles.
  - bit_out=0 and busy=0 at T+9.
- div=2, send 0x01:
  - bit_out=1 for cycles T+1..T+3, then 0 for 21 cycles.
  - bit_valid pulses at T+1, T+4, … T+22; busy for 24 cycles.
- Back-to-back at div=0: 0x0F at T, 0xF0 at T+1, 0x33 offered from T+2:
  - 24 contiguous bits with no gap.
  - in_ready=0 over T+2..T+8 and =1 at T+9; 0x33 is accepted at edge T+9 into the pending buffer.
  - frame_start at T+1, T+9, T+17.
- Reset mid-frame: assert rst_n=0 for one edge at T+4 during 0xFF:
  - next cycle bit_out=0, busy=0, in_ready=1, pending cleared.
  - A later 0x80 serializes normally.
- div changed from 0 to 3 during frame 0x0F:
  - the current frame keeps a 1-cycle period;
  - the following frame uses a 4-cycle period.
- With MEALY_SER_PARITY_EN, div=0, send 0x07:
  - 9 bits 1,1,1,0,0,0,0,0,1; busy for 9 cycles.
